// File: rtl/line_decoder_pkg.sv
// Shared encodings and helpers for the line_decoder_scan family.
package line_decoder_pkg;

  localparam logic [1:0] MODE_ONEHOT = 2'b00;
  localparam logic [1:0] MODE_THERM  = 2'b01;
  localparam logic [1:0] MODE_SCAN   = 2'b10;

  typedef enum logic [1:0] {
    ST_OFF  = 2'b00,
    ST_HOLD = 2'b01,
    ST_SCAN = 2'b10
  } st_e;

  function automatic int unsigned line_width(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/line_decoder_scan_if.sv
// Control and line-select bundle between a controller (master) and the decoder (slave).
interface line_decoder_scan_if #(
  parameter int unsigned N       = 2,
  parameter int unsigned DWELL_W = 4
) ();

  localparam int unsigned W = line_decoder_pkg::line_width(N);

  logic               EN;
  logic [1:0]         MODE;
  logic [N-1:0]       A;
  logic               LOAD;
  logic [DWELL_W-1:0] DWELL;
  logic [W-1:0]       D;
  logic               VALID;
  logic               WRAP;

  modport master (
    output EN, MODE, A, LOAD, DWELL,
    input  D, VALID, WRAP
  );

  modport slave (
    input  EN, MODE, A, LOAD, DWELL,
    output D, VALID, WRAP
  );

endinterface

// File: rtl/dwell_counter.sv
// Dwell counter for scan mode: emits a step pulse once every DWELL+1 running cycles.
module dwell_counter #(
  parameter int unsigned DWELL_W = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               clear,
  input  logic               run,
  input  logic [DWELL_W-1:0] DWELL,
  output logic               step
);

  logic [DWELL_W-1:0] cnt_q, cnt_d;

  // Equality compare: lowering DWELL below cnt lets the counter roll through its range.
  assign step = run && !clear && (cnt_q == DWELL);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = step ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/line_decoder_scan.sv
// Registered N-to-2^N line decoder with one-hot/thermometer coding and a self-running scan.
module line_decoder_scan
  import line_decoder_pkg::*;
#(
  parameter int unsigned N       = 2,
  parameter int unsigned DWELL_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  line_decoder_scan_if.slave bus
);

  localparam int unsigned W      = line_width(N);
  localparam logic [N-1:0] IdxMax = '1;

  st_e          st_q, st_d;
  logic [N-1:0] idx_q, idx_d;
  logic [W-1:0] d_q, d_d;
  logic         valid_q, valid_d;
  logic         wrap_q, wrap_d;
  logic         run, clear, step, therm;

  always_comb begin
    st_d = ST_OFF;
    if (bus.EN) begin
      st_d = (bus.MODE == MODE_SCAN) ? ST_SCAN : ST_HOLD;
    end
    // Counting only continues across edges that stay in SCAN; any entry restarts the dwell.
    run   = (st_q == ST_SCAN) && (st_d == ST_SCAN);
    clear = bus.LOAD || !run;
  end

  dwell_counter #(
    .DWELL_W(DWELL_W)
  ) u_dwell (
    .CLK  (CLK),
    .RST  (RST),
    .clear(clear),
    .run  (run),
    .DWELL(bus.DWELL),
    .step (step)
  );

  always_comb begin
    idx_d  = idx_q;
    wrap_d = 1'b0;
    if (bus.LOAD) begin
      idx_d = bus.A;
    end else if (step) begin
      idx_d  = idx_q + 1'b1;
      wrap_d = (idx_q == IdxMax);
    end

    therm   = (st_d == ST_HOLD) && (bus.MODE == MODE_THERM);
    valid_d = (st_d != ST_OFF);
    d_d     = '0;
    if (valid_d) begin
      for (int i = 0; i < int'(W); i++) begin
        d_d[i] = therm ? (i <= int'(idx_d)) : (i == int'(idx_d));
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st_q    <= ST_OFF;
      idx_q   <= '0;
      d_q     <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      idx_q   <= idx_d;
      d_q     <= d_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.D     = d_q;
  assign bus.VALID = valid_q;
  assign bus.WRAP  = wrap_q;

endmodule

// File: tb/tb_line_decoder_scan.sv
// Directed bench: N=2 instance for hold/scan/reset behaviour, N=3 instance for thermometer coding.
module tb_line_decoder_scan;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  line_decoder_scan_if #(.N(2), .DWELL_W(4)) bus_a ();
  line_decoder_scan_if #(.N(3), .DWELL_W(4)) bus_b ();

  line_decoder_scan #(.N(2), .DWELL_W(4)) u_dut_a (
    .CLK(clk),
    .RST(rst),
    .bus(bus_a)
  );

  line_decoder_scan #(.N(3), .DWELL_W(4)) u_dut_b (
    .CLK(clk),
    .RST(rst),
    .bus(bus_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [3:0] scan_seq [13];

  initial begin
    scan_seq = '{4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h4, 4'h4, 4'h4,
                 4'h8, 4'h8, 4'h8, 4'h1};

    rst = 1'b0;
    bus_a.EN = 1'b0; bus_a.MODE = 2'b00; bus_a.A = '0; bus_a.LOAD = 1'b0; bus_a.DWELL = '0;
    bus_b.EN = 1'b0; bus_b.MODE = 2'b00; bus_b.A = '0; bus_b.LOAD = 1'b0; bus_b.DWELL = '0;
    #2 rst = 1'b1;
    #2;
    chk("rst_d", 32'(bus_a.D), 32'h0);
    chk("rst_valid", 32'(bus_a.VALID), 32'h0);
    chk("rst_wrap", 32'(bus_a.WRAP), 32'h0);
    chk("rst_d_b", 32'(bus_b.D), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // One-hot hold, thermometer hold, disable.
    bus_a.EN = 1'b1; bus_a.MODE = 2'b00; bus_a.LOAD = 1'b1; bus_a.A = 2'd2;
    tick();
    chk("onehot_d", 32'(bus_a.D), 32'h4);
    chk("onehot_valid", 32'(bus_a.VALID), 32'h1);
    chk("onehot_wrap", 32'(bus_a.WRAP), 32'h0);
    bus_a.LOAD = 1'b0; bus_a.MODE = 2'b01;
    tick();
    chk("therm2_d", 32'(bus_a.D), 32'h7);
    bus_a.EN = 1'b0;
    tick();
    chk("off_d", 32'(bus_a.D), 32'h0);
    chk("off_valid", 32'(bus_a.VALID), 32'h0);

    // Load while disabled, then scan DWELL=2 through a full wrap.
    bus_a.LOAD = 1'b1; bus_a.A = 2'd0;
    tick();
    chk("load_off_d", 32'(bus_a.D), 32'h0);
    chk("load_off_valid", 32'(bus_a.VALID), 32'h0);
    bus_a.LOAD = 1'b0; bus_a.EN = 1'b1; bus_a.MODE = 2'b10; bus_a.DWELL = 4'd2;
    for (int i = 0; i < 13; i++) begin
      tick();
      chk($sformatf("scan_d[%0d]", i), 32'(bus_a.D), 32'(scan_seq[i]));
      chk($sformatf("scan_wrap[%0d]", i), 32'(bus_a.WRAP), (i == 12) ? 32'h1 : 32'h0);
    end
    chk("scan_valid", 32'(bus_a.VALID), 32'h1);

    // DWELL=0: every cycle steps; LOAD beats a scheduled step.
    bus_a.EN = 1'b0;
    tick();
    chk("scan_off_d", 32'(bus_a.D), 32'h0);
    bus_a.EN = 1'b1; bus_a.DWELL = 4'd0; bus_a.LOAD = 1'b1; bus_a.A = 2'd3;
    tick();
    chk("d0_load3_d", 32'(bus_a.D), 32'h8);
    chk("d0_load3_wrap", 32'(bus_a.WRAP), 32'h0);
    bus_a.LOAD = 1'b0;
    tick();
    chk("d0_wrap_d", 32'(bus_a.D), 32'h1);
    chk("d0_wrap_wrap", 32'(bus_a.WRAP), 32'h1);
    tick();
    chk("d0_step_d", 32'(bus_a.D), 32'h2);
    chk("d0_step_wrap", 32'(bus_a.WRAP), 32'h0);
    bus_a.LOAD = 1'b1; bus_a.A = 2'd1;
    tick();
    chk("loadwins_d", 32'(bus_a.D), 32'h2);
    chk("loadwins_wrap", 32'(bus_a.WRAP), 32'h0);
    bus_a.LOAD = 1'b0;
    tick();
    chk("after_load_d", 32'(bus_a.D), 32'h4);
    tick();
    chk("pre_rst_d", 32'(bus_a.D), 32'h8);

    // Asynchronous reset mid-scan at idx=3, then restart from idx=0.
    rst = 1'b1;
    #2;
    chk("async_rst_d", 32'(bus_a.D), 32'h0);
    chk("async_rst_valid", 32'(bus_a.VALID), 32'h0);
    chk("async_rst_wrap", 32'(bus_a.WRAP), 32'h0);
    bus_a.DWELL = 4'd1;
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("restart_d", 32'(bus_a.D), 32'h1);
    chk("restart_valid", 32'(bus_a.VALID), 32'h1);
    tick();
    chk("restart_hold_d", 32'(bus_a.D), 32'h1);
    tick();
    chk("restart_s1_d", 32'(bus_a.D), 32'h2);
    tick();
    chk("restart_s1h_d", 32'(bus_a.D), 32'h2);
    tick();
    chk("restart_s2_d", 32'(bus_a.D), 32'h4);

    // Pause scan at idx=2 for 5 cycles, resume with a full hold.
    bus_a.EN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("pause_d[%0d]", i), 32'(bus_a.D), 32'h0);
    end
    chk("pause_valid", 32'(bus_a.VALID), 32'h0);
    bus_a.EN = 1'b1;
    tick();
    chk("resume_d", 32'(bus_a.D), 32'h4);
    chk("resume_valid", 32'(bus_a.VALID), 32'h1);
    tick();
    chk("resume_hold_d", 32'(bus_a.D), 32'h4);
    tick();
    chk("resume_step_d", 32'(bus_a.D), 32'h8);

    // N=3 thermometer and reserved-mode coding.
    bus_b.EN = 1'b1; bus_b.MODE = 2'b01; bus_b.LOAD = 1'b1; bus_b.A = 3'd5;
    tick();
    chk("therm_a5", 32'(bus_b.D), 32'h3F);
    chk("therm_valid", 32'(bus_b.VALID), 32'h1);
    bus_b.A = 3'd0;
    tick();
    chk("therm_a0", 32'(bus_b.D), 32'h01);
    bus_b.A = 3'd7;
    tick();
    chk("therm_a7", 32'(bus_b.D), 32'hFF);
    bus_b.LOAD = 1'b0; bus_b.MODE = 2'b11;
    tick();
    chk("rsvd_mode_d", 32'(bus_b.D), 32'h80);
    bus_b.LOAD = 1'b1; bus_b.A = 3'd4; bus_b.MODE = 2'b00;
    tick();
    chk("onehot_b_a4", 32'(bus_b.D), 32'h10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_decoder_scan.md
# line_decoder_scan

Parametrised, registered N-to-2^N line decoder with enable, the next generation of the team's 2-to-4 structural decoder. It adds three things: selectable one-hot or thermometer output coding, a self-running scan mode that walks the active line at a programmable dwell rate, and registered outputs with a valid flag. It sits between control logic and line-select consumers such as display digit strobes, bank selects and mux enables.

## Interface
- N, default 2: select width; output width is 2^N. Legal range 1..6.
- DWELL_W, default 4: width of the scan dwell counter.
- CLK  in  1  clock; all state changes on its rising edge.
- RST  in  1  reset; asynchronous, active-high.
- EN  in  1  output enable, sampled on CLK.
- MODE  in  2  00 one-hot, 01 thermometer, 10 scan, 11 reserved (treated as 00).
- A  in  N  select index, captured when LOAD=1.
- LOAD  in  1  capture A into the index register.
- DWELL  in  DWELL_W  scan hold count; each line is held DWELL+1 cycles.
- D  out  2^N  decoded lines, registered.
- VALID  out  1  D reflects an enabled, loaded or scanning index.
- WRAP  out  1  one-cycle pulse when scan steps from index 2^N-1 to 0.

## Operation
- Internal state:
  - idx: N-bit index.
  - cnt: DWELL_W-bit dwell counter.
  - st: FSM state, one of OFF, HOLD, SCAN.
- Reset (asynchronous): idx=0, cnt=0, st=OFF, D=0, VALID=0, WRAP=0.
- OFF:
  - D=0, VALID=0.
  - Goes to HOLD when EN=1 and MODE is not 10.
  - Goes to SCAN when EN=1 and MODE=10.
- HOLD:
  - One-hot: D[i]=1 only for i=idx.
  - Thermometer: D[i]=1 for all i<=idx. idx=0 gives D=...0001; idx=2^N-1 gives all ones.
  - VALID=1.
- SCAN:
  - Output coding is one-hot.
  - cnt increments each cycle. When cnt==DWELL: cnt becomes 0 and idx becomes idx+1 modulo 2^N.
  - When idx steps from 2^N-1 to 0, WRAP=1 for that same D update cycle.
- EN=0 in any state: go to OFF on the next edge. idx is retained and cnt is cleared. Re-enabling resumes from the retained idx.
- LOAD=1 (any state, EN ignored): idx<=A and cnt<=0. LOAD has priority over the scan step in the same cycle; no WRAP is produced by a load.
- MODE change between 00/01 and 10 while EN=1: state switches on the next edge and cnt clears. idx is retained.
- DWELL changes take effect at the next comparison.
  - If DWELL is lowered below the current cnt, the counter rolls through its full range before matching. This is accepted behaviour; software loads DWELL while EN=0.
- Arithmetic is unsigned throughout. The idx increment wraps naturally at N bits; the cnt compare is an equality compare.

## Timing
- Latency: inputs sampled at edge k are reflected on D, VALID and WRAP after edge k. All outputs come straight from registers with no combinational path from inputs to outputs.
- LOAD at edge k in HOLD: new D is visible after edge k.
- Scan period per line is exactly DWELL+1 cycles. DWELL=0 steps the line every cycle.
- WRAP asserts for exactly one cycle, coincident with D=...0001 after the wrap.
- Reset asserted mid-scan clears all outputs immediately, with no clock required. The first enabled edge after reset release loads D from idx=0.

## Structure
- Shared package `line_decoder_pkg`: MODE encodings (MODE_ONEHOT, MODE_THERM, MODE_SCAN), FSM state encoding (ST_OFF, ST_HOLD, ST_SCAN), and a function computing the output width 2^N.
- Sub-module `dwell_counter`, parametrised by DWELL_W:
  - Inputs: CLK, RST, clear, run, DWELL.
  - Output: a step pulse.
- The decode and thermometer generation is a combinational function of idx and mode, feeding the D register.

## Test plan
- N=2, EN=1, MODE=00, LOAD A=2 → D=0100 and VALID=1 one cycle later; then EN=0 → D=0000, VALID=0 next cycle.
- N=3, MODE=01, LOAD A=5 → D=00111111; LOAD A=0 → D=00000001; LOAD A=7 → D=11111111.
- N=2, MODE=10, DWELL=2, start idx=0 → D sequence 0001×3, 0010×3, 0100×3, 1000×3, 0001. WRAP is high only in the cycle D returns to 0001.
- SCAN with DWELL=0 and LOAD A=1 in the same cycle as a scheduled step → D=0010 (load wins), cnt restarts, no WRAP.
- Assert RST asynchronously mid-scan at idx=3 → D=0, VALID=0, WRAP=0 before the next edge. After release with EN=1 and MODE=10 → scan restarts at D=0001.
- EN=0 for 5 cycles during SCAN at idx=2, then EN=1 → scan resumes at D=0100 with a full DWELL+1 hold.
